// File: rtl/world_editor.sv
// World-memory write controller: applies player REMOVE/PLACE edits to the cube BRAM
// between renderer frames. PLACE scans every slot for a free entry and for duplicates.
module world_editor #(
    parameter int unsigned COORD_WIDTH  = 32,
    parameter int unsigned WORLD_SIZE   = 100,
    parameter int unsigned WORLD_BITS   = 7,
    parameter int unsigned NORMAL_WIDTH = 2,
    parameter int unsigned READ_LATENCY = 3
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  place_req,
    input  logic                                  remove_req,
    input  logic [WORLD_BITS-1:0]                 target_cube,
    input  logic [2:0][NORMAL_WIDTH-1:0]          target_normal,
    input  logic                                  draw_busy,
    output logic [WORLD_BITS-1:0]                 mem_addr,
    input  logic [3*(COORD_WIDTH/2):0]            mem_dout,
    output logic [3*(COORD_WIDTH/2):0]            mem_din,
    output logic                                  mem_we,
    output logic                                  busy,
    output logic                                  done,
    output logic [1:0]                            status
);

    localparam int unsigned CW = COORD_WIDTH / 2;
    localparam int unsigned LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    localparam logic [1:0] StatOk       = 2'd0;
    localparam logic [1:0] StatInvalid  = 2'd1;
    localparam logic [1:0] StatOccupied = 2'd2;
    localparam logic [1:0] StatFull     = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRdTarget,
        StScan,
        StWrite,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [WORLD_BITS-1:0]       addr_q, addr_d;
    logic [LW-1:0]               cnt_q, cnt_d;
    logic [2:0][NORMAL_WIDTH-1:0] normal_q, normal_d;
    logic [2:0][CW-1:0]          new_q, new_d;
    logic [WORLD_BITS-1:0]       free_q, free_d;
    logic                        found_q, found_d;
    logic                        place_q, place_d;
    logic [1:0]                  status_q, status_d;

    logic                        dout_valid;
    logic [2:0][CW-1:0]          dout_xyz;
    logic [2:0][CW:0]            wide;
    logic [2:0][CW-1:0]          sum;
    logic                        ovf;
    logic                        sample;
    logic                        last_slot;
    logic                        target_bad;
    logic                        hit;
    logic                        free_now;

    assign dout_valid = mem_dout[3*CW];
    assign dout_xyz   = mem_dout[3*CW-1:0];
    assign sample     = (cnt_q == LW'(READ_LATENCY));
    assign last_slot  = (addr_q == WORLD_BITS'(WORLD_SIZE - 1));
    assign target_bad = (target_cube == '1) ||
                        ({1'b0, target_cube} >= (WORLD_BITS + 1)'(WORLD_SIZE));
    assign hit        = dout_valid && (dout_xyz == new_q);
    assign free_now   = !found_q && !dout_valid;

    // One extra bit per axis exposes signed overflow as a mismatch of the top two bits.
    always_comb begin
        ovf  = 1'b0;
        wide = '0;
        sum  = '0;
        for (int i = 0; i < 3; i++) begin
            wide[i] = {dout_xyz[i][CW-1], dout_xyz[i]} +
                      {{(CW + 1 - NORMAL_WIDTH){normal_q[i][NORMAL_WIDTH-1]}}, normal_q[i]};
            sum[i]  = wide[i][CW-1:0];
            ovf     = ovf | (wide[i][CW] ^ wide[i][CW-1]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            cnt_q    <= '0;
            normal_q <= '0;
            new_q    <= '0;
            free_q   <= '0;
            found_q  <= 1'b0;
            place_q  <= 1'b0;
            status_q <= StatOk;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            normal_q <= normal_d;
            new_q    <= new_d;
            free_q   <= free_d;
            found_q  <= found_d;
            place_q  <= place_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        normal_d = normal_q;
        new_d    = new_q;
        free_d   = free_q;
        found_d  = found_q;
        place_d  = place_q;
        status_d = status_q;

        case (state_q)
            StIdle: begin
                if (!draw_busy && (place_req || remove_req)) begin
                    addr_d   = target_cube;
                    normal_d = target_normal;
                    place_d  = !remove_req;
                    cnt_d    = '0;
                    if (target_bad) begin
                        status_d = StatInvalid;
                        state_d  = StDone;
                    end else if (remove_req) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRdTarget;
                    end
                end
            end
            StRdTarget: begin
                if (!sample) begin
                    cnt_d = cnt_q + LW'(1);
                end else if (!dout_valid || ovf) begin
                    status_d = StatInvalid;
                    state_d  = StDone;
                end else begin
                    new_d   = sum;
                    addr_d  = '0;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (!sample) begin
                    cnt_d = cnt_q + LW'(1);
                end else if (hit) begin
                    status_d = StatOccupied;
                    state_d  = StDone;
                end else begin
                    if (free_now) begin
                        free_d  = addr_q;
                        found_d = 1'b1;
                    end
                    if (!last_slot) begin
                        addr_d = addr_q + WORLD_BITS'(1);
                        cnt_d  = '0;
                    end else if (found_q || free_now) begin
                        addr_d  = free_now ? addr_q : free_q;
                        state_d = StWrite;
                    end else begin
                        status_d = StatFull;
                        state_d  = StDone;
                    end
                end
            end
            StWrite: begin
                status_d = StatOk;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign mem_we   = (state_q == StWrite);
    // REMOVE writes all-zero data, clearing the valid bit.
    assign mem_din  = (state_q == StWrite && place_q) ? {1'b1, new_q} : '0;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign status   = status_q;

endmodule
